pe: RTL and testbench
=====================

# pe

Processing element for a 3x3 convolution datapath. Each clock it multiplies one input activation by one filter weight and accumulates the product. After a fixed window of KERNEL_N consecutive samples it requantizes the sum to 8 bits, registers it on pe_out, and starts a new window. It sits in the convolution array between the activation/weight feeders and the output buffer.

## Interface
- DATA_W, 8: width of pe_in, pe_filter and pe_out.
- KERNEL_N, 9: products accumulated per window (3x3 kernel).
- SHIFT, 0: right-shift applied to the window sum before saturation.
- ACC_W, 2*DATA_W + clog2(KERNEL_N) = 20: accumulator width (derived; not to be overridden).
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- pe_in  input  DATA_W  unsigned input activation, sampled every rising edge.
- pe_filter  input  DATA_W  unsigned filter weight, sampled every rising edge.
- pe_out  output  DATA_W  registered, requantized result of the last completed window.

## Operation
- All arithmetic is unsigned.
- Product p = pe_in * pe_filter, 2*DATA_W bits wide.
- State:
  - cnt, the sample index 0..KERNEL_N-1.
  - acc, ACC_W bits.
  - out_r, which drives pe_out.
- Every rising edge with rst low:
  - cnt == 0: acc <= p. This starts a new window and discards the previous sum.
  - 0 < cnt < KERNEL_N-1: acc <= acc + p.
  - cnt == KERNEL_N-1: sum = acc + p. out_r <= min(sum >> SHIFT, 2^DATA_W - 1). acc is not used again until the next window restarts it.
  - cnt increments, wrapping from KERNEL_N-1 to 0.
- Windows run back to back with no idle cycles. There is no valid/enable input: every edge out of reset consumes one sample.
- Saturation: any shifted sum above 255 (DATA_W=8) yields 255. There is no wrap-around on pe_out.
- ACC_W is sized so acc never overflows. The worst case is 9*255*255 = 585225, which is below 2^20.
- pe_out holds its value between window completions.

## Timing
- rst high, asynchronously: cnt=0, acc=0, out_r=0, so pe_out=0 immediately. All of these hold while rst stays high.
- First rising edge after rst falls: samples window element 0.
- The KERNEL_N-th edge after reset release samples the last element. pe_out updates on that same edge, giving a latency of 0 cycles after the final sample (result visible just after the edge).
- Subsequent pe_out updates occur exactly every KERNEL_N edges.
- Inputs must be stable around each rising edge. The result uses only the values sampled on the window's edges.
- Reset mid-window discards the partial sum and sets pe_out to 0. The next window starts at index 0 on the first edge after release.
- Reset coinciding with a window-completing edge: reset wins, and pe_out = 0.

## Test plan
- Reset: hold rst=1 for 2 cycles with pe_in=10, pe_filter=10 -> pe_out=0 throughout. No update occurs while in reset.
- Hold pe_in=5, pe_filter=5 for 9 edges after reset release -> pe_out=225 after edge 9. It stays 225 through the next 8 edges when the same inputs are held.
- Hold pe_in=2, pe_filter=2 for 9 edges -> pe_out=36. In a following window with 20/20 (sum 3600) -> pe_out=255 (saturated).
- Hold pe_in=10, pe_filter=10 for 9 edges (sum 900) -> pe_out=255. Hold 255/255 for 9 edges (sum 585225) -> pe_out=255, with no accumulator wrap.
- Mixed window of products 1,2,...,9 (e.g. pe_in=k, pe_filter=1) -> pe_out=45. The next window of pe_filter=0 -> pe_out=0, confirming the accumulator restarts per window.
- Apply 4 samples of 5/5, assert rst for 1 cycle, then 9 samples of 2/2 -> pe_out=0 during reset, then 36, with no residue from the aborted window. Repeat with SHIFT=2 and 9x10/10 -> 900>>2=225.

Source files
------------

// File: rtl/pe.sv
// Processing element: unsigned multiply-accumulate over a fixed window of
// KERNEL_N samples. At the end of each window the sum is shifted right by
// SHIFT and saturated to DATA_W bits, then held on pe_out until the next
// window completes.
module pe #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned KERNEL_N = 9,
  parameter int unsigned SHIFT    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pe_in,
  input  logic [DATA_W-1:0] pe_filter,
  output logic [DATA_W-1:0] pe_out
);

  // Accumulator is sized for the worst-case window sum, so it never wraps.
  localparam int unsigned ACC_W  = 2 * DATA_W + $clog2(KERNEL_N);
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned CNT_W  = (KERNEL_N > 1) ? $clog2(KERNEL_N) : 1;

  localparam logic [CNT_W-1:0]  CntLast = CNT_W'(KERNEL_N - 1);
  localparam logic [DATA_W-1:0] OutMax  = {DATA_W{1'b1}};

  logic [CNT_W-1:0]  r_cnt;
  logic [ACC_W-1:0]  r_acc;
  logic [DATA_W-1:0] r_out;

  logic [CNT_W-1:0]  w_cnt_d;
  logic [ACC_W-1:0]  w_acc_d;
  logic [DATA_W-1:0] w_out_d;

  logic [PROD_W-1:0] w_prod;
  logic [ACC_W-1:0]  w_sum;
  logic [ACC_W-1:0]  w_shifted;
  logic              w_last;
  logic              w_first;
  logic              w_sat;

  // Product and running sum, including the sample arriving on this edge.
  always_comb begin
    w_prod    = PROD_W'(pe_in) * PROD_W'(pe_filter);
    w_sum     = r_acc + ACC_W'(w_prod);
    w_shifted = w_sum >> SHIFT;
    w_first   = (r_cnt == '0);
    w_last    = (r_cnt == CntLast);
    // Any set bit above the output width means the value does not fit.
    w_sat     = (w_shifted > ACC_W'(OutMax));
  end

  // Next-state for sample index, accumulator and output register.
  always_comb begin
    w_cnt_d = r_cnt + 1'b1;
    w_acc_d = r_acc;
    w_out_d = r_out;

    if (w_last) begin
      w_cnt_d = '0;
      w_out_d = w_sat ? OutMax : w_shifted[DATA_W-1:0];
    end

    // With KERNEL_N == 1 the first sample is also the last; the window sum
    // is then just the product, which w_sum yields only if acc is zero, so
    // the first-sample path discards the old sum explicitly.
    if (w_first) begin
      w_acc_d = ACC_W'(w_prod);
      if (w_last) begin
        w_out_d = (ACC_W'(w_prod >> SHIFT) > ACC_W'(OutMax)) ?
                  OutMax : w_prod[DATA_W-1+SHIFT -: DATA_W];
      end
    end else if (!w_last) begin
      w_acc_d = w_sum;
    end
  end

  // State registers; reset clears the partial window and the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_out <= '0;
    end else begin
      r_cnt <= w_cnt_d;
      r_acc <= w_acc_d;
      r_out <= w_out_d;
    end
  end

  assign pe_out = r_out;

endmodule

// File: tb/tb_pe.sv
// Scoreboard bench for pe: the stimulus process pushes the expected pe_out
// after every edge for two instances (SHIFT=0 and SHIFT=2); a monitor pops
// and compares just after each rising edge.
module tb_pe;

  localparam int unsigned DATA_W = 8;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] pe_in;
  logic [DATA_W-1:0] pe_filter;
  logic [DATA_W-1:0] pe_out0;
  logic [DATA_W-1:0] pe_out2;

  typedef struct {
    logic [DATA_W-1:0] e0;
    logic [DATA_W-1:0] e2;
    string             name;
  } exp_t;

  exp_t q[$];

  int n_checks;
  int n_fails;

  logic [DATA_W-1:0] h0;
  logic [DATA_W-1:0] h2;

  pe #(.DATA_W(8), .KERNEL_N(9), .SHIFT(0)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .pe_in     (pe_in),
    .pe_filter (pe_filter),
    .pe_out    (pe_out0)
  );

  pe #(.DATA_W(8), .KERNEL_N(9), .SHIFT(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .pe_in     (pe_in),
    .pe_filter (pe_filter),
    .pe_out    (pe_out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare both instances just after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check({e.name, "/shift0"}, pe_out0, e.e0);
      check({e.name, "/shift2"}, pe_out2, e.e2);
    end
  end

  // One sample, driven at the falling edge, with the output expected after
  // the following rising edge.
  task automatic drive(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic r, input logic [DATA_W-1:0] e0,
                       input logic [DATA_W-1:0] e2, input string name);
    exp_t e;
    @(negedge clk);
    rst       = r;
    pe_in     = a;
    pe_filter = b;
    e.e0 = e0;
    e.e2 = e2;
    e.name = name;
    q.push_back(e);
  endtask

  // Constant-input window: output holds for 8 edges, then updates.
  task automatic window(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input logic [DATA_W-1:0] e0, input logic [DATA_W-1:0] e2,
                        input string name);
    for (int i = 0; i < 8; i++) drive(a, b, 1'b0, h0, h2, {name, "_hold"});
    drive(a, b, 1'b0, e0, e2, name);
    h0 = e0;
    h2 = e2;
  endtask

  // Reset cycles; pe_out must clear asynchronously, before any edge.
  task automatic reset_cycles(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      drive(8'd10, 8'd10, 1'b1, 8'd0, 8'd0, name);
      if (i == 0) begin
        #1;
        check({name, "_async0"}, pe_out0, 8'd0);
        check({name, "_async2"}, pe_out2, 8'd0);
      end
    end
    h0 = '0;
    h2 = '0;
  endtask

  initial begin
    int budget;
    n_checks  = 0;
    n_fails   = 0;
    h0        = '0;
    h2        = '0;
    rst       = 1'b1;
    pe_in     = 8'd10;
    pe_filter = 8'd10;

    reset_cycles(2, "reset");
    window(8'd5, 8'd5, 8'd225, 8'd56, "w5x5");
    window(8'd5, 8'd5, 8'd225, 8'd56, "w5x5_again");
    window(8'd2, 8'd2, 8'd36, 8'd9, "w2x2");
    window(8'd20, 8'd20, 8'd255, 8'd255, "w20x20_sat");
    window(8'd10, 8'd10, 8'd255, 8'd225, "w10x10");
    window(8'd255, 8'd255, 8'd255, 8'd255, "w255_max");

    // Products 1..9: sum 45.
    for (int k = 1; k <= 8; k++) drive(8'(k), 8'd1, 1'b0, h0, h2, "mixed_hold");
    drive(8'd9, 8'd1, 1'b0, 8'd45, 8'd11, "mixed");
    h0 = 8'd45;
    h2 = 8'd11;
    window(8'd7, 8'd0, 8'd0, 8'd0, "zero_filter");
    window(8'd3, 8'd3, 8'd81, 8'd20, "w3x3");

    // Aborted window: reset after 4 samples must leave no residue.
    for (int i = 0; i < 4; i++) drive(8'd5, 8'd5, 1'b0, h0, h2, "abort_pre");
    reset_cycles(1, "abort_rst");
    window(8'd2, 8'd2, 8'd36, 8'd9, "after_abort");
    window(8'd10, 8'd10, 8'd255, 8'd225, "w10x10_end");

    budget = 0;
    while (q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (q.size() > 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
